// File: rtl/hazard_stall_ctrl.sv
// Hazard sequencer for the 5-stage core: load-use bubbles, HI/LO mult/div occupancy stalls,
// taken-branch flushes, plus saturating stall/flush event counters.
module hazard_stall_ctrl #(
    parameter int MD_LATENCY = 32,
    parameter int CNT_W      = 6,
    parameter int PERF_W     = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [4:0]        id_rs_i,
    input  logic [4:0]        id_rt_i,
    input  logic              id_uses_rt_i,
    input  logic              id_md_start_i,
    input  logic              id_md_read_i,
    input  logic              ex_mem_read_i,
    input  logic [4:0]        ex_rt_i,
    input  logic              branch_taken_i,
    output logic              pc_write_o,
    output logic              if_id_write_o,
    output logic              id_ex_bubble_o,
    output logic              if_id_flush_o,
    output logic              id_ex_flush_o,
    output logic              md_start_o,
    output logic              md_busy_o,
    output logic              md_done_o,
    output logic [PERF_W-1:0] stall_cnt_o,
    output logic [PERF_W-1:0] flush_cnt_o
);

    typedef enum logic {S_IDLE = 1'b0, S_BUSY = 1'b1} state_t;

    localparam logic [CNT_W-1:0] LP_MD_LOAD = CNT_W'(MD_LATENCY - 1);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [CNT_W-1:0]   r_md_cnt;
    logic [PERF_W-1:0]  r_stall_cnt;
    logic [PERF_W-1:0]  r_flush_cnt;

    logic w_ld_haz;
    logic w_md_haz;
    logic w_stall;
    logic w_md_accept;
    logic w_md_busy;
    logic w_md_done;

    assign w_md_busy = (r_state == S_BUSY);
    assign w_md_done = w_md_busy && (r_md_cnt == '0);

    // A load into $zero never creates a real dependency.
    assign w_ld_haz = ex_mem_read_i && (ex_rt_i != 5'd0) &&
                      ((ex_rt_i == id_rs_i) || (id_uses_rt_i && (ex_rt_i == id_rt_i)));
    assign w_md_haz = w_md_busy && (id_md_read_i || id_md_start_i);

    // A squashed ID instruction cannot stall the pipe.
    assign w_stall     = (w_ld_haz || w_md_haz) && !branch_taken_i;
    assign w_md_accept = id_md_start_i && !w_stall && !branch_taken_i;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_IDLE: if (w_md_accept) w_state_nxt = S_BUSY;
            S_BUSY: if (w_md_done)   w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        pc_write_o     = 1'b1;
        if_id_write_o  = 1'b1;
        id_ex_bubble_o = 1'b0;
        if_id_flush_o  = 1'b0;
        id_ex_flush_o  = 1'b0;
        md_start_o     = 1'b0;
        md_busy_o      = 1'b0;
        md_done_o      = 1'b0;
        if (!rst_i) begin
            md_start_o = w_md_accept;
            md_busy_o  = w_md_busy;
            md_done_o  = w_md_done;
            if (branch_taken_i) begin
                if_id_flush_o = 1'b1;
                id_ex_flush_o = 1'b1;
            end else if (w_stall) begin
                pc_write_o     = 1'b0;
                if_id_write_o  = 1'b0;
                id_ex_bubble_o = 1'b1;
            end
        end
    end

    // Busy lasts MD_LATENCY cycles: load LATENCY-1, done fires when the count reaches zero.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_md_cnt <= '0;
        end else if (!w_md_busy && w_md_accept) begin
            r_md_cnt <= LP_MD_LOAD;
        end else if (w_md_busy && (r_md_cnt != '0)) begin
            r_md_cnt <= r_md_cnt - CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (w_stall && (r_stall_cnt != '1))
                r_stall_cnt <= r_stall_cnt + PERF_W'(1);
            if (branch_taken_i && (r_flush_cnt != '1))
                r_flush_cnt <= r_flush_cnt + PERF_W'(1);
        end
    end

    assign stall_cnt_o = r_stall_cnt;
    assign flush_cnt_o = r_flush_cnt;

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Bench for hazard_stall_ctrl: directed scenarios plus random traffic against a cycle-count model,
// and a narrow-counter instance for saturation.
module tb_hazard_stall_ctrl;

    localparam int LAT  = 32;
    localparam longint PMAX = 64'hFFFF_FFFF;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, id_uses_rt, id_md_start, id_md_read, ex_mem_read, br;
    logic [4:0] id_rs, id_rt, ex_rt;
    logic       pc_write, if_id_write, bubble, if_id_flush, id_ex_flush;
    logic       md_start, md_busy, md_done;
    logic [31:0] stall_cnt, flush_cnt;

    hazard_stall_ctrl #(.MD_LATENCY(LAT), .CNT_W(6), .PERF_W(32)) dut (
        .clk_i(clk), .rst_i(rst), .id_rs_i(id_rs), .id_rt_i(id_rt), .id_uses_rt_i(id_uses_rt),
        .id_md_start_i(id_md_start), .id_md_read_i(id_md_read), .ex_mem_read_i(ex_mem_read),
        .ex_rt_i(ex_rt), .branch_taken_i(br), .pc_write_o(pc_write), .if_id_write_o(if_id_write),
        .id_ex_bubble_o(bubble), .if_id_flush_o(if_id_flush), .id_ex_flush_o(id_ex_flush),
        .md_start_o(md_start), .md_busy_o(md_busy), .md_done_o(md_done),
        .stall_cnt_o(stall_cnt), .flush_cnt_o(flush_cnt)
    );

    // Narrow instance for counter saturation.
    logic       s_zero1 = 1'b0;
    logic [4:0] s_zero5 = 5'd0;
    logic       s_ex_mem_read;
    logic [4:0] s_ex_rt, s_id_rs;
    logic       s_pc_write, s_if_id_write, s_bubble, s_if_id_flush, s_id_ex_flush;
    logic       s_md_start, s_md_busy, s_md_done;
    logic [3:0] s_stall_cnt, s_flush_cnt;

    hazard_stall_ctrl #(.MD_LATENCY(4), .CNT_W(3), .PERF_W(4)) dut_s (
        .clk_i(clk), .rst_i(rst), .id_rs_i(s_id_rs), .id_rt_i(s_zero5), .id_uses_rt_i(s_zero1),
        .id_md_start_i(s_zero1), .id_md_read_i(s_zero1), .ex_mem_read_i(s_ex_mem_read),
        .ex_rt_i(s_ex_rt), .branch_taken_i(s_zero1), .pc_write_o(s_pc_write),
        .if_id_write_o(s_if_id_write), .id_ex_bubble_o(s_bubble), .if_id_flush_o(s_if_id_flush),
        .id_ex_flush_o(s_id_ex_flush), .md_start_o(s_md_start), .md_busy_o(s_md_busy),
        .md_done_o(s_md_done), .stall_cnt_o(s_stall_cnt), .flush_cnt_o(s_flush_cnt)
    );

    int checks = 0;
    int errors = 0;

    // Model: remaining busy cycles of the HI/LO unit and plain event tallies.
    int     m_rem;
    longint m_stall, m_flush;
    logic   last_pc, last_done, last_busy;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        id_rs = 5'd0; id_rt = 5'd0; id_uses_rt = 1'b0; id_md_start = 1'b0; id_md_read = 1'b0;
        ex_mem_read = 1'b0; ex_rt = 5'd0; br = 1'b0;
    endtask

    // Inputs are set at the negedge; check #1 later, advance model across the posedge.
    task automatic cyc();
        bit ld, busy, mdh, st, e_start, e_done;
        #1;
        ld   = ex_mem_read && ex_rt != 0 && (ex_rt == id_rs || (id_uses_rt && ex_rt == id_rt));
        busy = m_rem > 0;
        mdh  = busy && (id_md_read || id_md_start);
        st   = (ld || mdh) && !br;
        if (rst) begin
            m_rem = 0; m_stall = 0; m_flush = 0;
            chk("pc_write", pc_write, 1); chk("if_id_write", if_id_write, 1);
            chk("bubble", bubble, 0); chk("if_id_flush", if_id_flush, 0);
            chk("id_ex_flush", id_ex_flush, 0); chk("md_start", md_start, 0);
            chk("md_busy", md_busy, 0); chk("md_done", md_done, 0);
            chk("stall_cnt", stall_cnt, 0); chk("flush_cnt", flush_cnt, 0);
            e_start = 0;
        end else begin
            e_start = id_md_start && !st && !br;
            e_done  = (m_rem == 1);
            chk("pc_write", pc_write, !st); chk("if_id_write", if_id_write, !st);
            chk("bubble", bubble, st); chk("if_id_flush", if_id_flush, br);
            chk("id_ex_flush", id_ex_flush, br); chk("md_start", md_start, e_start);
            chk("md_busy", md_busy, busy); chk("md_done", md_done, e_done);
            chk("stall_cnt", stall_cnt, m_stall); chk("flush_cnt", flush_cnt, m_flush);
        end
        last_pc = pc_write; last_done = md_done; last_busy = md_busy;
        @(posedge clk);
        if (!rst) begin
            if (busy) m_rem--;
            if (e_start) m_rem = LAT;
            if (st && m_stall < PMAX) m_stall++;
            if (br && m_flush < PMAX) m_flush++;
        end
        @(negedge clk);
    endtask

    initial begin
        int n, stalls, done_at, busy_cycles, dones;
        longint sc0;
        m_rem = 0; m_stall = 0; m_flush = 0;
        rst = 1'b1; idle_inputs();
        s_ex_mem_read = 1'b0; s_ex_rt = 5'd0; s_id_rs = 5'd0;
        @(negedge clk);
        // Reset state with a live load-use hazard on the inputs.
        ex_mem_read = 1'b1; ex_rt = 5'd8; id_rs = 5'd8;
        cyc();
        rst = 1'b0; idle_inputs();
        cyc();

        // Load-use: lw $t0 then add using $t0.
        ex_mem_read = 1'b1; ex_rt = 5'd8; id_rs = 5'd8;
        cyc();
        chk("lu_pc_write", last_pc, 0);
        idle_inputs();
        cyc();
        chk("lu_stall_cnt", stall_cnt, 1);

        // Load into $zero, and rt used only as destination.
        ex_mem_read = 1'b1; ex_rt = 5'd0; id_rs = 5'd0;
        cyc();
        chk("zero_dest_pc", last_pc, 1);
        ex_rt = 5'd8; id_rt = 5'd8; id_uses_rt = 1'b0; id_rs = 5'd3;
        cyc();
        chk("rt_dest_pc", last_pc, 1);
        idle_inputs();

        // mult then mflo: stalled until the unit completes.
        id_md_start = 1'b1;
        cyc();
        id_md_start = 1'b0; id_md_read = 1'b1;
        stalls = 0; done_at = -1; n = 0;
        while (n < 100) begin
            n++;
            cyc();
            if (last_done) done_at = n;
            if (last_pc) break;
            stalls++;
        end
        chk("md_stall_len", stalls, LAT);
        chk("md_done_at", done_at, LAT);
        idle_inputs();

        // Load-use coinciding with a taken branch.
        sc0 = stall_cnt;
        ex_mem_read = 1'b1; ex_rt = 5'd9; id_rt = 5'd9; id_uses_rt = 1'b1; br = 1'b1;
        cyc();
        idle_inputs();
        cyc();
        chk("br_stall_unchanged", stall_cnt, sc0);

        // Reset while BUSY with the count at 10.
        id_md_start = 1'b1;
        cyc();
        idle_inputs();
        repeat (21) cyc();
        rst = 1'b1;
        #1;
        chk("rst_busy_drop", md_busy, 0);
        chk("rst_no_done", md_done, 0);
        cyc();
        rst = 1'b0;
        id_md_start = 1'b1;
        cyc();
        idle_inputs();
        busy_cycles = 0; dones = 0; n = 0;
        while (n < 100) begin
            n++;
            cyc();
            if (!last_busy) break;
            busy_cycles++;
            if (last_done) dones++;
        end
        chk("rerun_busy_len", busy_cycles, LAT);
        chk("rerun_done_cnt", dones, 1);

        // Random traffic against the model.
        for (int i = 0; i < 600; i++) begin
            rst         = ($urandom_range(0, 99) == 0);
            id_rs       = 5'($urandom_range(0, 3));
            id_rt       = 5'($urandom_range(0, 3));
            ex_rt       = 5'($urandom_range(0, 3));
            id_uses_rt  = 1'($urandom_range(0, 1));
            ex_mem_read = ($urandom_range(0, 2) == 0);
            id_md_start = ($urandom_range(0, 5) == 0);
            id_md_read  = ($urandom_range(0, 5) == 0);
            br          = ($urandom_range(0, 7) == 0);
            cyc();
        end
        rst = 1'b0; idle_inputs();

        // 4-bit counter saturation under a permanent load-use stall.
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        s_ex_mem_read = 1'b1; s_ex_rt = 5'd8; s_id_rs = 5'd8;
        for (int i = 1; i <= 20; i++) begin
            cyc();
            chk("sat_stall_cnt", s_stall_cnt, (i < 15) ? i : 15);
        end
        s_ex_mem_read = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
